regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-read-port register file with write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-cycle CPU's 2-read/1-write file for the pipelined core. Decode reads operands through the read ports. Issue marks destination registers pending. Writeback commits data and clears the pending state. The hazard unit consumes the busy flags and the pending count.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (2..2**AW)
AW, 5, register address width
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads see stored value only
SP_IDX, 2, index of register given a non-zero reset value
SP_INIT, 32'h2ffc, reset value of register SP_IDX

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NUM_RD*XLEN  packed read data, combinational
rd_busy  out  NUM_RD  per-port pending flag for the addressed register, combinational
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback register
wr_data  in  XLEN  writeback data
sb_set  in  1  issue strobe: mark sb_addr pending
sb_addr  in  AW  destination register of the issued instruction
pend_cnt  out  $clog2(NREGS)+1  registered count of pending registers
sb_full  out  1  registered; 1 when pend_cnt == NREGS-1 (every writable register pending)

Behaviour:
- Reset is synchronous, active-high, clock clk; it takes effect at the first rising edge with reset=1.
  - On reset: all registers = 0 except reg[SP_IDX] = SP_INIT.
  - Busy bits, pend_cnt and sb_full are cleared.
  - wr_en and sb_set are ignored in any reset cycle.
  - Reset asserted mid-operation discards all pending state; no write completes in that cycle.
- Register 0 is hardwired zero:
  - reads of address 0 return 0 with rd_busy=0;
  - wr_en or sb_set to address 0 is ignored.
- Addresses >= NREGS:
  - reads return 0 with rd_busy=0;
  - writes and sets are ignored.
- Write: at a rising edge with wr_en=1 and a valid nonzero wr_addr, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Read (per port k, combinational, zero latency):
  - If BYPASS=1 and wr_en=1 and wr_addr == rd_addr_k (valid, nonzero): rd_data_k = wr_data and rd_busy_k = 0.
  - Otherwise: rd_data_k = reg[rd_addr_k] and rd_busy_k = busy[rd_addr_k].
  - All ports are independent; several ports on the same address return identical values.
- Scoreboard:
  - At a rising edge, sb_set=1 with a valid nonzero sb_addr sets busy[sb_addr].
  - sb_set on an already-busy register leaves it busy and pend_cnt unchanged.
  - If sb_set and wr_en target the same register in the same cycle, the data is written and the register stays busy; the set wins because a newer producer was issued.
  - A write to a register that is not busy is legal; data is written and busy stays 0.
- pend_cnt is maintained incrementally as a registered counter, never by a popcount. Per cycle it changes by:
  - +1 for an effective set of a non-busy register;
  - -1 for an effective clear of a busy register that is not re-set in the same cycle;
  - net 0 when both happen on different registers.
  - pend_cnt always equals the popcount of the busy bits.
- sb_full is registered alongside pend_cnt. When sb_full=1, the issuer must not assert sb_set for a non-busy register; if it does, the set is still applied as specified.

Test Plan:
- Reset: hold reset 2 cycles, then read all addresses on port 0 -> 0 everywhere except addr 2 = 32'h2ffc; pend_cnt=0, sb_full=0, rd_busy=0.
- Write/readback: write x5=32'hDEADBEEF, next cycle read x5 on both ports -> DEADBEEF on each; write x0=32'h1234 -> x0 reads 0.
- Bypass: in the same cycle drive wr_en x7=32'hA5A5A5A5 and rd_addr port1=7 -> rd_data1=A5A5A5A5 that cycle; with BYPASS=0 it shows the old value 0.
- Scoreboard: sb_set x3 -> next cycle rd_busy=1 for x3, pend_cnt=1. Then sb_set x4 with wr_en x3 in the same cycle -> x3 not busy, x4 busy, pend_cnt=1.
- Set/clear collision: x9 busy, then sb_set x9 and wr_en x9=32'h55 in the same cycle -> x9 reads 32'h55, rd_busy=1, pend_cnt unchanged.
- Saturation and mid-op reset: sb_set x1..x31 over 31 cycles -> pend_cnt=31, sb_full=1. Assert reset with wr_en x1=32'hFF active -> x1=0, pend_cnt=0, sb_full=0, x2=32'h2ffc.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with optional write-to-read bypass and a
// per-register pending-write scoreboard feeding the hazard unit.

module regfile_mp_sb_rdport #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]               addr,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic [NREGS-1:0]            busy,
    input  logic                        byp_en,
    input  logic [AW-1:0]               byp_addr,
    input  logic [XLEN-1:0]             byp_data,
    output logic [XLEN-1:0]             data,
    output logic                        pend
);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic valid;
    assign valid = (addr != '0) && ({1'b0, addr} < NREGS_W);

    // byp_en is only raised for a valid nonzero write address, so a match
    // here implies a legal register.
    always_comb begin
        data = '0;
        pend = 1'b0;
        if (valid) begin
            if (byp_en && (byp_addr == addr)) begin
                data = byp_data;
            end else begin
                data = regs[addr];
                pend = busy[addr];
            end
        end
    end
endmodule

module regfile_mp_sb #(
    parameter int               XLEN    = 32,
    parameter int               NREGS   = 32,
    parameter int               AW      = 5,
    parameter int               NUM_RD  = 2,
    parameter int               BYPASS  = 1,
    parameter int               SP_IDX  = 2,
    parameter logic [XLEN-1:0]  SP_INIT = 'h2ffc
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*XLEN-1:0]    rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [XLEN-1:0]           wr_data,
    input  logic                      sb_set,
    input  logic [AW-1:0]             sb_addr,
    output logic [$clog2(NREGS):0]    pend_cnt,
    output logic                      sb_full
);
    localparam int          CW      = $clog2(NREGS) + 1;
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_nxt;
    logic [CW-1:0]              cnt_nxt;
    logic                       wr_ok;
    logic                       set_ok;
    logic                       inc;
    logic                       dec;
    logic                       byp_en;

    assign wr_ok  = wr_en  && (wr_addr != '0) && ({1'b0, wr_addr} < NREGS_W);
    assign set_ok = sb_set && (sb_addr != '0) && ({1'b0, sb_addr} < NREGS_W);
    assign byp_en = (BYPASS != 0) && wr_ok;

    // A set in the same cycle as a write to the same register wins: a newer
    // producer has been issued, so that register stays pending.
    assign inc = set_ok && !busy[sb_addr];
    assign dec = wr_ok && busy[wr_addr] && !(set_ok && (sb_addr == wr_addr));
    assign cnt_nxt = pend_cnt + CW'(inc) - CW'(dec);

    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[wr_addr] = 1'b0;
        if (set_ok)
            busy_nxt[sb_addr] = 1'b1;
    end

    // Register 0 is never written, so it stays zero from reset onward.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs     <= '0;
            if (SP_IDX != 0 && SP_IDX < NREGS)
                regs[SP_IDX] <= SP_INIT;
            busy     <= '0;
            pend_cnt <= '0;
            sb_full  <= 1'b0;
        end else begin
            if (wr_ok)
                regs[wr_addr] <= wr_data;
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
            sb_full  <= (cnt_nxt == CW'(NREGS - 1));
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_mp_sb_rdport #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .addr     (rd_addr[k*AW +: AW]),
            .regs     (regs),
            .busy     (busy),
            .byp_en   (byp_en),
            .byp_addr (wr_addr),
            .byp_data (wr_data),
            .data     (rd_data[k*XLEN +: XLEN]),
            .pend     (rd_busy[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb; a BYPASS=0 copy shares the stimulus to
// show the stored-value-only read path.

module tb_regfile_mp_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [5:0]  pend_cnt, pend_cnt_nb;
    logic        sb_full, sb_full_nb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp_sb dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(pend_cnt), .sb_full(sb_full)
    );

    regfile_mp_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(pend_cnt_nb), .sb_full(sb_full_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        sb_set = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0;
        step(); step();
        reset = 1'b0;

        // reset contents
        for (int a = 0; a < 32; a++) begin
            rd_addr[4:0] = 5'(a);
            #1;
            chk($sformatf("rst_data_x%0d", a), rd_data[31:0], (a == 2) ? 32'h2ffc : 32'h0);
            chk($sformatf("rst_busy_x%0d", a), {31'b0, rd_busy[0]}, 32'h0);
        end
        chk("rst_pend", {26'b0, pend_cnt}, 32'd0);
        chk("rst_full", {31'b0, sb_full}, 32'd0);

        // write / readback on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step(); idle();
        rd_addr = {5'd5, 5'd5};
        #1;
        chk("wr_x5_p0", rd_data[31:0], 32'hDEADBEEF);
        chk("wr_x5_p1", rd_data[63:32], 32'hDEADBEEF);

        // x0 is hardwired
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        step(); idle();
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("wr_x0_p0", rd_data[31:0], 32'h0);
        chk("wr_x0_p1", rd_data[63:32], 32'h0);

        // same-cycle bypass
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd_addr = {5'd7, 5'd5};
        #1;
        chk("byp_x7", rd_data[63:32], 32'hA5A5A5A5);
        chk("nobyp_x7", rd_data_nb[63:32], 32'h0);
        chk("byp_p0_x5", rd_data[31:0], 32'hDEADBEEF);
        step(); idle();
        #1;
        chk("x7_after", rd_data[63:32], 32'hA5A5A5A5);
        chk("nb_x7_after", rd_data_nb[63:32], 32'hA5A5A5A5);

        // scoreboard set
        sb_set = 1'b1; sb_addr = 5'd3;
        step(); idle();
        rd_addr = {5'd4, 5'd3};
        #1;
        chk("sb_x3_busy", {31'b0, rd_busy[0]}, 32'd1);
        chk("sb_pend1", {26'b0, pend_cnt}, 32'd1);

        // set x4 while writing back x3
        sb_set = 1'b1; sb_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        chk("byp_x3_busy", {31'b0, rd_busy[0]}, 32'd0);
        chk("nb_x3_busy", {31'b0, rd_busy_nb[0]}, 32'd1);
        step(); idle();
        #1;
        chk("x3_clear", {31'b0, rd_busy[0]}, 32'd0);
        chk("x3_data", rd_data[31:0], 32'h33);
        chk("x4_busy", {31'b0, rd_busy[1]}, 32'd1);
        chk("pend_net0", {26'b0, pend_cnt}, 32'd1);

        // set/clear collision on x9
        sb_set = 1'b1; sb_addr = 5'd9;
        step(); idle();
        chk("pend_x9", {26'b0, pend_cnt}, 32'd2);
        sb_set = 1'b1; sb_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        step(); idle();
        rd_addr = {5'd9, 5'd9};
        #1;
        chk("coll_data", rd_data[31:0], 32'h55);
        chk("coll_busy", {31'b0, rd_busy[0]}, 32'd1);
        chk("coll_pend", {26'b0, pend_cnt}, 32'd2);

        // saturate x1..x31 (x4, x9 already pending)
        for (int i = 1; i < 32; i++) begin
            sb_set = 1'b1; sb_addr = 5'(i);
            step();
            if (i == 30) begin
                chk("sat_pend30", {26'b0, pend_cnt}, 32'd30);
                chk("sat_full30", {31'b0, sb_full}, 32'd0);
            end
        end
        idle();
        chk("sat_pend", {26'b0, pend_cnt}, 32'd31);
        chk("sat_full", {31'b0, sb_full}, 32'd1);

        // mid-operation reset swallows a write
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFF;
        step();
        reset = 1'b0; idle();
        rd_addr = {5'd2, 5'd1};
        #1;
        chk("mrst_x1", rd_data[31:0], 32'h0);
        chk("mrst_x1_busy", {31'b0, rd_busy[0]}, 32'd0);
        chk("mrst_x2", rd_data[63:32], 32'h2ffc);
        chk("mrst_pend", {26'b0, pend_cnt}, 32'd0);
        chk("mrst_full", {31'b0, sb_full}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
